// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit for the EX stage.
// Owns HI/LO; results are staged in pHI/pLO and commit after a fixed latency.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  Op,
  input  logic        Start,
  input  logic        Flush,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES
                                                   : MULT_CYCLES;
  localparam int CW   = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);

  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   phi_q, phi_d;
  logic [31:0]   plo_q, plo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d;

  logic          busy;
  logic          accept;

  logic          mul_s;
  logic [63:0]   ax, bx, prod;

  logic          div_s;
  logic [31:0]   a_mag, b_mag;
  logic [31:0]   dvd, dvs0, dvs;
  logic [31:0]   uq, ur, q, r;

  assign busy   = (cnt_q != '0);
  assign accept = Start && !busy && !Flush;

  // Sign-extend when signed so the low 64 bits form the signed product.
  assign mul_s = (Op == OP_MULT);
  assign ax    = {{32{mul_s & A[31]}}, A};
  assign bx    = {{32{mul_s & B[31]}}, B};
  assign prod  = ax * bx;

  // Signed divide on magnitudes avoids the INT_MIN / -1 overflow trap.
  assign div_s = (Op == OP_DIV);
  assign a_mag = A[31] ? -A : A;
  assign b_mag = B[31] ? -B : B;
  assign dvd   = div_s ? a_mag : A;
  assign dvs0  = div_s ? b_mag : B;
  assign dvs   = (dvs0 == '0) ? 32'd1 : dvs0;
  assign uq    = dvd / dvs;
  assign ur    = dvd % dvs;
  assign q     = (div_s && (A[31] ^ B[31])) ? -uq : uq;
  assign r     = (div_s && A[31]) ? -ur : ur;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    phi_d = phi_q;
    plo_d = plo_q;
    cnt_d = cnt_q;
    dz_d  = dz_q;
    if (Flush) begin
      cnt_d = '0;
      dz_d  = 1'b0;
    end else if (busy) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1) && !dz_q) begin
        hi_d = phi_q;
        lo_d = plo_q;
      end
    end else if (accept) begin
      unique case (Op)
        OP_MULT, OP_MULTU: begin
          {phi_d, plo_d} = prod;
          cnt_d          = CW'(MULT_CYCLES);
          dz_d           = 1'b0;
        end
        OP_DIV, OP_DIVU: begin
          plo_d = q;
          phi_d = r;
          cnt_d = CW'(DIV_CYCLES);
          dz_d  = (B == '0);
        end
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      phi_q <= '0;
      plo_q <= '0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      cnt_q <= cnt_d;
      dz_q  <= dz_d;
    end
  end

  assign Busy = busy;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit in the EX stage, alongside the ALU and fed by the same forwarded operand buses `A`/`B`. It executes MIPS MULT/MULTU/DIV/DIVU with fixed latency, owns the architectural HI/LO registers, and supports MTHI/MTLO writes. It raises `Busy` so the hazard unit can stall any MDU-dependent instruction, including MFHI/MFLO, in ID.

## Interface
- `MULT_CYCLES`, default 5: Busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: Busy cycles for DIV/DIVU.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `A` input 32: operand rs (multiplicand/dividend, or MTHI/MTLO data).
- `B` input 32: operand rt (multiplier/divisor).
- `Op` input 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
- `Start` input 1: issue `Op` this cycle.
- `Flush` input 1: abort any in-flight operation (exception/interrupt).
- `Busy` output 1: multi-cycle operation in flight.
- `HI` output 32: architectural HI register.
- `LO` output 32: architectural LO register.

## Operation
- Registers: `HI`, `LO`, pending result `pHI`/`pLO`, and down-counter `cnt` (4 bits minimum). `Busy = (cnt != 0)`.
- Reset (`reset_n` = 0 at an edge): HI=0, LO=0, cnt=0, Busy=0. Any in-flight operation is discarded. Reset overrides Start and Flush.
- Accept rule: `Start` is honoured only when Busy=0 and Flush=0. A Start with Busy=1 is ignored, because the stall logic never issues one.
- MULT on accept: {pHI,pLO} = signed(A)*signed(B) as a 64-bit product. cnt = MULT_CYCLES.
- MULTU on accept: {pHI,pLO} = A*B unsigned as a 64-bit product. cnt = MULT_CYCLES.
- DIV on accept: pLO = quotient truncated toward zero. pHI = remainder, which takes the sign of the dividend. cnt = DIV_CYCLES.
- DIVU on accept: pLO = A/B and pHI = A%B, both unsigned. cnt = DIV_CYCLES.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B=0, DIV or DIVU): the operation is accepted and Busy runs the full DIV_CYCLES. HI/LO are left unchanged at completion (commit is suppressed via a latched flag).
- MTHI/MTLO on accept: HI (resp. LO) = A at that same edge. cnt stays 0 and Busy is never raised.
- Op 110/111 with Start: no state change.
- Countdown: each edge with cnt != 0 and Flush=0 decrements cnt. On the edge where cnt goes 1→0, HI=pHI and LO=pLO (unless div-by-zero).
- Flush: at the edge, cnt=0 and the pending result is dropped. HI/LO keep their pre-operation values. Flush and Start in the same cycle: Flush wins and Start is dropped.
- Results are computed combinationally at accept and held in the pending registers. The latency is architectural, not a datapath requirement.

## Timing
- Start accepted at edge T → Busy=1 in cycles T+1 … T+N (N = MULT_CYCLES or DIV_CYCLES). At edge T+N, HI/LO take the new values and Busy=0. Readers see the new HI/LO in the first cycle Busy is low.
- Back-to-back: Start in the first cycle Busy=0 is accepted, so there are zero idle cycles between operations.
- HI/LO do not change during Busy; they retain the previous values until commit.
- MTHI/MTLO: new value is visible the cycle after the accept edge (one-cycle latency).
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: assert reset_n=0 with Start=1, Op=MULT → HI=LO=0, Busy=0. After release, Busy stays 0.
- MULT A=0xFFFFFFFF, B=2 → Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=-7 (0xFFFFFFF9), B=2 → after 10 Busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU A=100, B=0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO → Busy 10 cycles, then HI=0x11, LO=0x22 unchanged.
- Flush in the 3rd Busy cycle of MULT 3×4 (prior HI/LO=5/6) → Busy=0 the next cycle, HI/LO stay 5/6. Start+Flush together → ignored.
- Back-to-back: MULTU 3×4 with Start re-asserted (DIVU 9/2) the cycle Busy falls → LO=12, then 10 cycles later LO=4, HI=1. A Start during Busy is ignored.
